ex_stage: RTL

Execute stage of the RV32I pipeline. Consumes the ID/EX register outputs (operation select, operands, immediate, PC, destination), computes the ALU result and branch/jump resolution, and registers results toward EX/MEM. Shifts run through an iterative 1-bit-per-cycle unit that drives `ex_stall` back to ID/EX to hold the instruction until the result is ready.

---
 rtl/ex_stage_pkg.sv | 61 ++++++
 rtl/ex_stage_serial_shifter.sv | 65 ++++++
 rtl/ex_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// Shared constants for the RV32I execute stage: bus widths, ALU select encodings,
// shifter FSM states and shift helpers.
package ex_stage_pkg;

  localparam logic RstEnable = 1'b0;

  localparam int unsigned AluSelBus   = 5;
  localparam int unsigned RegBus      = 32;
  localparam int unsigned ImmBus      = 32;
  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned RegAddrBus  = 5;

  localparam logic [AluSelBus-1:0] ALU_NOP   = 5'd0;
  localparam logic [AluSelBus-1:0] ALU_ADD   = 5'd1;
  localparam logic [AluSelBus-1:0] ALU_SUB   = 5'd2;
  localparam logic [AluSelBus-1:0] ALU_SLT   = 5'd3;
  localparam logic [AluSelBus-1:0] ALU_SLTU  = 5'd4;
  localparam logic [AluSelBus-1:0] ALU_XOR   = 5'd5;
  localparam logic [AluSelBus-1:0] ALU_OR    = 5'd6;
  localparam logic [AluSelBus-1:0] ALU_AND   = 5'd7;
  localparam logic [AluSelBus-1:0] ALU_SLL   = 5'd8;
  localparam logic [AluSelBus-1:0] ALU_SRL   = 5'd9;
  localparam logic [AluSelBus-1:0] ALU_SRA   = 5'd10;
  localparam logic [AluSelBus-1:0] ALU_LUI   = 5'd11;
  localparam logic [AluSelBus-1:0] ALU_AUIPC = 5'd12;
  localparam logic [AluSelBus-1:0] ALU_JAL   = 5'd13;
  localparam logic [AluSelBus-1:0] ALU_JALR  = 5'd14;
  localparam logic [AluSelBus-1:0] ALU_BEQ   = 5'd15;
  localparam logic [AluSelBus-1:0] ALU_BNE   = 5'd16;
  localparam logic [AluSelBus-1:0] ALU_BLT   = 5'd17;
  localparam logic [AluSelBus-1:0] ALU_BGE   = 5'd18;
  localparam logic [AluSelBus-1:0] ALU_BLTU  = 5'd19;
  localparam logic [AluSelBus-1:0] ALU_BGEU  = 5'd20;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  typedef enum logic [1:0] {ShSll, ShSrl, ShSra} sh_op_e;

  function automatic sh_op_e alusel_to_shop(input logic [AluSelBus-1:0] sel);
    sh_op_e op;
    case (sel)
      ALU_SRL: op = ShSrl;
      ALU_SRA: op = ShSra;
      default: op = ShSll;
    endcase
    return op;
  endfunction

  function automatic logic [RegBus-1:0] shift_by(input sh_op_e op, input logic [RegBus-1:0] v,
                                                 input logic [4:0] n);
    logic [RegBus-1:0] r;
    case (op)
      ShSrl:   r = v >> n;
      ShSra:   r = $signed(v) >>> n;
      default: r = v << n;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_stage_serial_shifter.sv
// Iterative 1-bit-per-cycle shifter with IDLE/SHIFT FSM; raises the stall toward ID/EX
// until the result is available on the completing edge.
module serial_shifter
  import ex_stage_pkg::*;
#(
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  sh_op_e             i_op,
  input  logic [RegBus-1:0]  i_opr,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_stall,
  output logic [RegBus-1:0]  o_result
);

  logic [0:0]         r_state;
  logic [RegBus-1:0]  r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  sh_op_e             r_op;
  logic [RegBus-1:0]  w_acc_next;
  logic               w_last;

  assign w_acc_next = shift_by(r_op, r_acc, 5'd1);
  assign w_last     = (r_cnt == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_op    <= ShSll;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_acc   <= i_opr;
            r_cnt   <= i_shamt;
            r_op    <= i_op;
            r_state <= StShift;
          end
        end
        StShift: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - SHAMT_W'(1);
          if (w_last) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    o_busy   = (r_state == StShift);
    o_done   = o_busy && w_last;
    // The final edge of SHIFT releases ID/EX so the next instruction advances with the result.
    o_stall  = (rst != RstEnable) &&
               (((r_state == StIdle) && i_start) || (o_busy && (r_cnt > SHAMT_W'(1))));
    o_result = w_acc_next;
  end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, branch resolution and EX/MEM output registers.
// Define BARREL_SHIFT_EN for single-cycle shifts (no stall); default is the serial shifter.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned SHAMT_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AluSelBus-1:0]   ex_alusel,
  input  logic [RegBus-1:0]      ex_opr1,
  input  logic [RegBus-1:0]      ex_opr2,
  input  logic [ImmBus-1:0]      ex_opr3,
  input  logic [InstAddrBus-1:0] ex_opr4,
  input  logic [RegAddrBus-1:0]  ex_wd,
  input  logic                   ex_wreg,
  output logic                   ex_stall,
  output logic [RegAddrBus-1:0]  mem_wd,
  output logic                   mem_wreg,
  output logic [RegBus-1:0]      mem_wdata,
  output logic                   branch_flag,
  output logic [InstAddrBus-1:0] branch_target
);

  logic [RegAddrBus-1:0]  r_mem_wd;
  logic                   r_mem_wreg;
  logic [RegBus-1:0]      r_mem_wdata;
  logic                   r_branch_flag;
  logic [InstAddrBus-1:0] r_branch_target;

  logic [RegAddrBus-1:0]  w_wd;
  logic                   w_wreg;
  logic [RegBus-1:0]      w_wdata;
  logic                   w_flag;
  logic [InstAddrBus-1:0] w_target;

  logic                   w_is_shift;
  logic [SHAMT_W-1:0]     w_shamt;
  logic                   w_shift_imm;
  logic [RegBus-1:0]      w_shift_imm_val;
  logic                   w_sh_busy;
  logic                   w_sh_done;
  logic [RegBus-1:0]      w_sh_result;
  logic                   w_taken;
  logic [InstAddrBus-1:0] w_pc_rel;
  logic [InstAddrBus-1:0] w_link;

  assign w_is_shift = (ex_alusel == ALU_SLL) || (ex_alusel == ALU_SRL) || (ex_alusel == ALU_SRA);
  assign w_shamt    = ex_opr2[SHAMT_W-1:0];
  assign w_pc_rel   = ex_opr4 + ex_opr3;
  assign w_link     = ex_opr4 + 32'd4;

`ifdef BARREL_SHIFT_EN
  assign w_sh_busy       = 1'b0;
  assign w_sh_done       = 1'b0;
  assign w_sh_result     = '0;
  assign w_shift_imm     = 1'b1;
  assign w_shift_imm_val = shift_by(alusel_to_shop(ex_alusel), ex_opr1, 5'(w_shamt));
  assign ex_stall        = 1'b0;
`else
  assign w_shift_imm     = (w_shamt == '0);
  assign w_shift_imm_val = ex_opr1;

  serial_shifter #(
    .SHAMT_W (SHAMT_W)
  ) u_serial_shifter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_is_shift && !w_shift_imm),
    .i_op     (alusel_to_shop(ex_alusel)),
    .i_opr    (ex_opr1),
    .i_shamt  (w_shamt),
    .o_busy   (w_sh_busy),
    .o_done   (w_sh_done),
    .o_stall  (ex_stall),
    .o_result (w_sh_result)
  );
`endif

  always_comb begin
    w_taken = 1'b0;
    case (ex_alusel)
      ALU_BEQ:  w_taken = (ex_opr1 == ex_opr2);
      ALU_BNE:  w_taken = (ex_opr1 != ex_opr2);
      ALU_BLT:  w_taken = ($signed(ex_opr1) < $signed(ex_opr2));
      ALU_BGE:  w_taken = ($signed(ex_opr1) >= $signed(ex_opr2));
      ALU_BLTU: w_taken = (ex_opr1 < ex_opr2);
      ALU_BGEU: w_taken = (ex_opr1 >= ex_opr2);
      default:  w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_wd     = '0;
    w_wreg   = 1'b0;
    w_wdata  = '0;
    w_flag   = 1'b0;
    w_target = '0;
    if (w_sh_busy) begin
      // Inputs are frozen during SHIFT, so the held wd/wreg belong to the shift.
      if (w_sh_done) begin
        w_wd    = ex_wd;
        w_wreg  = ex_wreg;
        w_wdata = w_sh_result;
      end
    end else begin
      case (ex_alusel)
        ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND,
        ALU_LUI, ALU_AUIPC, ALU_JAL, ALU_JALR: begin
          w_wd   = ex_wd;
          w_wreg = ex_wreg;
        end
        ALU_SLL, ALU_SRL, ALU_SRA: begin
          if (w_shift_imm) begin
            w_wd   = ex_wd;
            w_wreg = ex_wreg;
          end
        end
        default: ;
      endcase
      case (ex_alusel)
        ALU_ADD:   w_wdata = ex_opr1 + ex_opr2;
        ALU_SUB:   w_wdata = ex_opr1 - ex_opr2;
        ALU_SLT:   w_wdata = {31'd0, $signed(ex_opr1) < $signed(ex_opr2)};
        ALU_SLTU:  w_wdata = {31'd0, ex_opr1 < ex_opr2};
        ALU_XOR:   w_wdata = ex_opr1 ^ ex_opr2;
        ALU_OR:    w_wdata = ex_opr1 | ex_opr2;
        ALU_AND:   w_wdata = ex_opr1 & ex_opr2;
        ALU_SLL, ALU_SRL, ALU_SRA: begin
          if (w_shift_imm) w_wdata = w_shift_imm_val;
        end
        ALU_LUI:   w_wdata = ex_opr3;
        ALU_AUIPC: w_wdata = w_pc_rel;
        ALU_JAL: begin
          w_wdata  = w_link;
          w_flag   = 1'b1;
          w_target = w_pc_rel;
        end
        ALU_JALR: begin
          w_wdata  = w_link;
          w_flag   = 1'b1;
          w_target = (ex_opr1 + ex_opr3) & ~32'd1;
        end
        ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU: begin
          w_flag   = w_taken;
          w_target = w_taken ? w_pc_rel : '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_mem_wd        <= '0;
      r_mem_wreg      <= 1'b0;
      r_mem_wdata     <= '0;
      r_branch_flag   <= 1'b0;
      r_branch_target <= '0;
    end else begin
      r_mem_wd        <= w_wd;
      r_mem_wreg      <= w_wreg;
      r_mem_wdata     <= w_wdata;
      r_branch_flag   <= w_flag;
      r_branch_target <= w_target;
    end
  end

  assign mem_wd        = r_mem_wd;
  assign mem_wreg      = r_mem_wreg;
  assign mem_wdata     = r_mem_wdata;
  assign branch_flag   = r_branch_flag;
  assign branch_target = r_branch_target;

endmodule
